sfq_clocked_gate: RTL
=====================

# sfq_clocked_gate

Cycle-based behavioural model of a clocked RSFQ logic gate, generalised from the two-input clocked AND to N data inputs with a selectable Boolean function. Data pulses arrive as one-cycle strobes and are latched per input. A gate-clock strobe evaluates the latched inputs, emits the result pulse after a fixed clock-to-output delay, and clears the gate. The block also checks double-pulse and setup-time violations, so cell timing descriptions can be exercised in system-level benches.

## Interface
- `N`, 2: number of data-pulse inputs, 2..16.
- `MODE`, 0: gate function; 0 AND, 1 OR, 2 XOR (odd parity), 3 MAJ (strictly more than N/2 set).
- `SETUP`, 2: minimum cycles between a data pulse and the following gate clock; 0 disables the check.
- `LATENCY`, 3: cycles from gate-clock strobe to `dout` pulse, 1..32.
- `ERR_W`, 8: width of the saturating error counter.
- `clk`, in, 1: system clock. Every event is sampled on its rising edge.
- `rst`, in, 1: asynchronous reset, active-high.
- `din`, in, N: data pulse strobes. A one-cycle high on bit i is one SFQ pulse on input i.
- `sclk`, in, 1: gate-clock pulse strobe.
- `dout`, out, 1: output pulse strobe, one cycle wide.
- `stored`, out, N: current per-input latched state, for observation.
- `err_double`, out, 1: one-cycle pulse when a data pulse hits an already-set input.
- `err_setup`, out, 1: one-cycle pulse when an evaluation includes a setup-violating input.
- `err_cnt`, out, ERR_W: saturating count of all error events.

## Operation
- Per input i, `stored[i]` is 0 (idle) or 1 (pulse held). Together the bits form the 2^N gate state.
- **Data pulse, no `sclk`.**
  - If `stored[i]`=0: set it, and reset `age[i]` to 0.
  - If `stored[i]`=1: ignore the pulse. This is the error state, and the gate does not fire. Raise `err_double` next cycle. The original arrival age is kept.
- **`sclk` strobe.**
  - Evaluate `f(stored)` according to MODE and push the result into the delay line.
  - Clear all `stored` bits.
  - If SETUP>0 and any set input has `age` < SETUP, raise `err_setup` next cycle. The evaluation still uses that input.
- **Simultaneous `din[i]` and `sclk`.**
  - The clock evaluates first, using the pre-cycle state.
  - The new pulse is then stored for the next period, with `age` 0.
  - No `err_double` is raised, even if `stored[i]` was 1.
- **Age counters.** `age[i]` increments each cycle while `stored[i]`=1 and saturates at SETUP. Width is clog2(SETUP+1), minimum 1.
- **Error counter.** `err_cnt` adds `err_double` + `err_setup` each cycle (0, 1 or 2) and saturates at 2^ERR_W−1.
- **Output.** `dout` is high for exactly one cycle per evaluation that yields 1. Evaluations yielding 0 produce nothing.
- **Back-to-back `sclk` strobes** are legal. Each strobe occupies its own delay-line slot.

## Timing
- **`sclk` to `dout`:** a `sclk` sampled at edge k gives `dout` high during the cycle after edge k+LATENCY.
- **`stored` update:** visible the cycle after the `din` or `sclk` edge.
- **Error pulses:** `err_double` and `err_setup` are registered, one cycle after the causing edge. `err_cnt` updates on the same edge as the error pulse.
- **Reset** (asynchronous, takes effect immediately):
  - `stored`=0, `age`=0, delay line cleared, `dout`=0, `err_double`=0, `err_setup`=0, `err_cnt`=0.
  - Pulses in flight are dropped.
  - The first events honoured are those sampled on the first edge after `rst` deasserts.
- **SETUP check:** a pulse at edge j followed by `sclk` at edge j+d is a violation iff 1 ≤ d < SETUP. The d=0 case is the simultaneous rule above.

## Structure
- **Package `sfq_gate_pkg`:**
  - mode constants `MODE_AND`, `MODE_OR`, `MODE_XOR`, `MODE_MAJ`;
  - function `sfq_eval(mode, bits)`;
  - the age-width helper.
- **Sub-module `sfq_pulse_delay`:** parametrised LATENCY-deep 1-bit shift line with asynchronous clear. It is reused by other cell models for clock-to-output delay.
- **Top level:** the per-input latch/age logic and the checks are generated with a for-loop over N.

## Test plan
1. **AND, double pulse.** N=2, MODE=0. Pulse `din[0]` at t=2 and again at t=4, `din[1]` at t=6, `sclk` at t=10.
   - `err_double` at t=5.
   - `dout` at t=14 (LATENCY=3).
   - `stored`=0 at t=11; `err_cnt`=1.
2. **AND, one input missing.** `din[1]` only, then `sclk`.
   - No `dout`; `stored` clears.
   - A following `din[0]`, `din[1]`, `sclk` sequence yields one `dout`.
3. **MODE sweep.** N=3, pattern 3'b011 then `sclk`, for each MODE.
   - AND: no pulse. OR: pulse. XOR: no pulse. MAJ: pulse.
4. **Setup violation.** SETUP=2. `din[0]`/`din[1]` at t=8, `sclk` at t=9.
   - `err_setup` at t=10.
   - `dout` still fires at t=13.
5. **Simultaneous events.** `stored`=2'b11; `din[0]` and `sclk` at the same edge.
   - `dout` fires; no `err_double`.
   - `stored`=2'b01 afterwards.
6. **Reset mid-flight.** Assert `rst` one cycle after an `sclk` whose result is 1.
   - No `dout` ever appears; all outputs are 0 during reset.
   - With ERR_W=2, five double-pulse errors saturate `err_cnt` at 3.

Source files
------------

// File: rtl/sfq_gate_pkg.sv
// sfq_gate_pkg: shared constants and helpers for clocked SFQ gate models
package sfq_gate_pkg;

  localparam int MODE_AND = 0;
  localparam int MODE_OR  = 1;
  localparam int MODE_XOR = 2;
  localparam int MODE_MAJ = 3;
  localparam int MAX_N    = 16;

  // Width of an age counter that saturates at setup; never narrower than one bit.
  function automatic int sfq_age_w(input int setup);
    return (setup < 1) ? 1 : $clog2(setup + 1);
  endfunction

  // Gate function over the low n bits; bits at or above n are ignored.
  function automatic logic sfq_eval(input int mode, input logic [MAX_N-1:0] bits, input int n);
    int ones;
    ones = 0;
    for (int i = 0; i < MAX_N; i++)
      if (i < n && bits[i]) ones++;
    return (mode == MODE_AND) ? (ones == n) :
           (mode == MODE_OR)  ? (ones > 0) :
           (mode == MODE_XOR) ? ones[0] :
                                (2 * ones > n);
  endfunction

endpackage

// File: rtl/sfq_pulse_delay.sv
// sfq_pulse_delay: LATENCY-deep 1-bit pulse shift line with asynchronous clear
module sfq_pulse_delay #(
  parameter int LATENCY = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [LATENCY-1:0] sr;
  logic [LATENCY:0]   nxt;

  assign nxt  = {sr, din};
  assign dout = sr[LATENCY-1];

  // shift the pulse one stage per cycle; reset drops anything in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else sr <= nxt[LATENCY-1:0];

endmodule

// File: rtl/sfq_clocked_gate.sv
// sfq_clocked_gate: N-input clocked RSFQ gate with double-pulse and setup checks
module sfq_clocked_gate
  import sfq_gate_pkg::*;
#(
  parameter int N       = 2,
  parameter int MODE    = 0,
  parameter int SETUP   = 2,
  parameter int LATENCY = 3,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     din,
  input  logic             sclk,
  output logic             dout,
  output logic [N-1:0]     stored,
  output logic             err_double,
  output logic             err_setup,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int AW = sfq_age_w(SETUP);
  localparam logic [AW-1:0] AGE_MAX = AW'(SETUP);

  logic [N-1:0] dbl;
  logic [N-1:0] viol;
  logic         fire;
  logic [ERR_W:0] cnt_sum;

  for (genvar i = 0; i < N; i++) begin : g_in
    logic          st;
    logic [AW-1:0] age;
    logic          set_new;
    // a pulse is accepted into an empty input, or alongside sclk which empties it first
    assign set_new   = din[i] & (sclk | ~st);
    assign dbl[i]    = din[i] & st & ~sclk;
    assign viol[i]   = (SETUP > 0) && sclk && st && (int'(age) + 1 < SETUP);
    assign stored[i] = st;
    // per-input pulse latch and arrival age; age counts cycles since the pulse landed
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        st  <= 1'b0;
        age <= '0;
      end else begin
        st  <= set_new | (st & ~sclk);
        age <= set_new ? '0 : (st && age != AGE_MAX) ? age + 1'b1 : age;
      end
  end

  assign cnt_sum = {1'b0, err_cnt} + (ERR_W+1)'(|dbl) + (ERR_W+1)'(|viol);

  // evaluate on sclk from pre-edge state; register error pulses and saturating count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fire       <= 1'b0;
      err_double <= 1'b0;
      err_setup  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      fire       <= sclk && sfq_eval(MODE, MAX_N'(stored), N);
      err_double <= |dbl;
      err_setup  <= |viol;
      err_cnt    <= cnt_sum[ERR_W] ? '1 : cnt_sum[ERR_W-1:0];
    end

  sfq_pulse_delay #(.LATENCY(LATENCY)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (fire),
    .dout (dout)
  );

endmodule
